// File: rtl/sap_pkg.sv
// Shared SAP fetch-path definitions: default geometry, the program-counter
// operation encoding, and the strobe priority decoder.
package sap_pkg;

  localparam int unsigned SAP_ADDR_W      = 4;
  localparam int unsigned SAP_STACK_DEPTH = 4;
  localparam int unsigned SAP_RESET_ADDR  = 0;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LD,
    PC_CALL,
    PC_RET
  } pc_op_t;

  // One operation per edge: ret > call > ld > inc; the rest are ignored.
  function automatic pc_op_t decode_op(input logic ret, input logic call,
                                       input logic ld, input logic inc);
    pc_op_t op;
    op = PC_HOLD;
    if (ret)       op = PC_RET;
    else if (call) op = PC_CALL;
    else if (ld)   op = PC_LD;
    else if (inc)  op = PC_INC;
    return op;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Control strobes and status/bus signals between the controller (master)
// and the program sequencer (slave).
interface program_sequencer_if #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               inc;
  logic               ld;
  logic               call;
  logic               ret;
  logic [ADDR_W-1:0]  ld_addr;
  logic               pc_out_en;
  logic [ADDR_W-1:0]  bus_out;
  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] depth;
  logic               stk_full;
  logic               stk_empty;
  logic               wrap;
  logic               err;

  modport master (
    output inc, ld, call, ret, ld_addr, pc_out_en,
    input  bus_out, pc, depth, stk_full, stk_empty, wrap, err
  );

  modport slave (
    input  inc, ld, call, ret, ld_addr, pc_out_en,
    output bus_out, pc, depth, stk_full, stk_empty, wrap, err
  );
endinterface

// File: rtl/return_stack.sv
// Return-address LIFO. Only the occupancy pointer is reset; entries at or
// above the pointer are never read, so the storage needs no reset.
module return_stack #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  din,
  output logic [ADDR_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  // Storage is sized to the pointer's range so every index is in bounds.
  localparam int unsigned SLOTS = 1 << DEPTH_W;

  logic [ADDR_W-1:0]  mem [SLOTS];
  logic [DEPTH_W-1:0] ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (ptr == DEPTH_W'(STACK_DEPTH));
  assign empty   = (ptr == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign depth   = ptr;
  assign top     = mem[ptr - DEPTH_W'(1)];

  // Occupancy pointer, cleared asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          ptr <= '0;
    else if (do_push) ptr <= ptr + DEPTH_W'(1);
    else if (do_pop)  ptr <= ptr - DEPTH_W'(1);
  end

  // Entry write on push.
  always_ff @(posedge clk) begin
    if (do_push) mem[ptr] <= din;
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: pc register with inc/jump/call/ret, return-address
// stack, wrap pulse, sticky error flag and tri-state W-bus driver.
module program_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W      = SAP_ADDR_W,
  parameter int unsigned STACK_DEPTH = SAP_STACK_DEPTH,
  parameter int unsigned RESET_ADDR  = SAP_RESET_ADDR
) (
  input logic                 clk,
  input logic                 clr,
  program_sequencer_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  pc_op_t             op;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;
  logic               push;
  logic               pop;
  logic               illegal;
  logic               wrap_q;
  logic               err_q;

  // Strobe priority decode.
  always_comb begin
    op = decode_op(bus.ret, bus.call, bus.ld, bus.inc);
  end

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign push    = (op == PC_CALL) && !stk_full;
  assign pop     = (op == PC_RET) && !stk_empty;
  assign illegal = ((op == PC_CALL) && stk_full) || ((op == PC_RET) && stk_empty);

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Program counter update for the decoded operation.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= ADDR_W'(RESET_ADDR);
    end else begin
      case (op)
        PC_INC:  pc_q <= pc_inc;
        PC_LD:   pc_q <= bus.ld_addr;
        PC_CALL: if (!stk_full) pc_q <= bus.ld_addr;
        PC_RET:  if (!stk_empty) pc_q <= stk_top;
        default: pc_q <= pc_q;
      endcase
    end
  end

  // Wrap pulses only for the cycle after an inc from all-ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) wrap_q <= 1'b0;
    else     wrap_q <= (op == PC_INC) && (pc_q == '1);
  end

  // Sticky error on call-when-full or ret-when-empty.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign bus.pc        = pc_q;
  assign bus.bus_out   = bus.pc_out_en ? pc_q : 'z;
  assign bus.depth     = stk_depth;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

endmodule
